// File: rtl/lsu_pkg.sv
// Shared load/store unit constants: dcache uop codes, default geometry, FSM encoding.
// Also imported by the dcache and its bench, so the codes here must stay in sync with them.
package lsu_pkg;
    localparam logic [3:0] STR_UOP = 4'b1001;
    localparam logic [3:0] LDR_UOP = 4'b1010;
    localparam logic [3:0] NOP_UOP = 4'b0000;

    localparam int LSU_ADDR_W       = 5;
    localparam int LSU_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_FAULT  = 3'd4
    } lsu_state_t;

    function automatic logic is_mem_uop(input logic [3:0] uop);
        return (uop == STR_UOP) || (uop == LDR_UOP);
    endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute request, dcache bus, writeback and exception signals of lsu_ctrl.
// slave = lsu_ctrl side; master = the surrounding pipeline/dcache side.
interface lsu_ctrl_if import lsu_pkg::*; #(
    parameter int ADDR_W = LSU_ADDR_W
) ();
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_uop;
    logic [31:0]       req_base;
    logic [31:0]       req_offset;
    logic [31:0]       req_data;
    logic [3:0]        req_rd;

    logic [ADDR_W-1:0] dc_addr;
    logic [31:0]       dc_data_in;
    logic [3:0]        dc_uop;
    logic [31:0]       dc_data_out;

    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        wb_rd;
    logic [31:0]       wb_data;

    logic              exc_valid;
    logic [31:0]       exc_addr;

    modport slave (
        input  req_valid, req_uop, req_base, req_offset, req_data, req_rd,
        input  dc_data_out, wb_ready,
        output req_ready, dc_addr, dc_data_in, dc_uop,
        output wb_valid, wb_rd, wb_data, exc_valid, exc_addr
    );

    modport master (
        output req_valid, req_uop, req_base, req_offset, req_data, req_rd,
        output dc_data_out, wb_ready,
        input  req_ready, dc_addr, dc_data_in, dc_uop,
        input  wb_valid, wb_rd, wb_data, exc_valid, exc_addr
    );
endinterface

// File: rtl/lsu_addr_gen.sv
// Effective address generation: base+offset (mod 2^32), word address, legality.
// Purely combinational, no state.
module lsu_addr_gen import lsu_pkg::*; #(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic [31:0]       base,
    input  logic [31:0]       offset,
    output logic [31:0]       ea,
    output logic [ADDR_W-1:0] word_addr,
    output logic              legal
);
    always_comb begin
        ea        = base + offset;
        word_addr = ea[ADDR_W+1:2];
        legal     = (ea[1:0] == 2'b00) && (ea[31:ADDR_W+2] == '0);
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control ahead of dcache: one request in flight, registered outputs; store 1 cycle,
// load READ_LATENCY+1 cycles to wb_valid. req_ready only in IDLE; wb result held until wb_ready.
module lsu_ctrl import lsu_pkg::*; #(
    parameter int ADDR_W       = LSU_ADDR_W,
    parameter int READ_LATENCY = LSU_READ_LATENCY
) (
    input  logic     clock,
    input  logic     reset,
    lsu_ctrl_if.slave bus
);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    lsu_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [3:0]        rd_q, rd_d;

    logic [31:0]       ea;
    logic [ADDR_W-1:0] word_addr;
    logic              legal;
    logic              accept;

    logic [3:0]        dc_uop_d;
    logic [ADDR_W-1:0] dc_addr_d;
    logic [31:0]       dc_data_in_d;
    logic              wb_valid_d;
    logic [3:0]        wb_rd_d;
    logic [31:0]       wb_data_d;
    logic              exc_valid_d;
    logic [31:0]       exc_addr_d;
    logic              req_ready_d;

    lsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .base      (bus.req_base),
        .offset    (bus.req_offset),
        .ea        (ea),
        .word_addr (word_addr),
        .legal     (legal)
    );

    assign accept = bus.req_valid & bus.req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rd_q           <= '0;
            bus.req_ready  <= 1'b0;
            bus.dc_uop     <= NOP_UOP;
            bus.dc_addr    <= '0;
            bus.dc_data_in <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_rd      <= '0;
            bus.wb_data    <= '0;
            bus.exc_valid  <= 1'b0;
            bus.exc_addr   <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            rd_q           <= rd_d;
            bus.req_ready  <= req_ready_d;
            bus.dc_uop     <= dc_uop_d;
            bus.dc_addr    <= dc_addr_d;
            bus.dc_data_in <= dc_data_in_d;
            bus.wb_valid   <= wb_valid_d;
            bus.wb_rd      <= wb_rd_d;
            bus.wb_data    <= wb_data_d;
            bus.exc_valid  <= exc_valid_d;
            bus.exc_addr   <= exc_addr_d;
        end
    end

    // In ACCESS the registered dc_uop still carries the accepted uop, so it selects store vs load.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (accept && is_mem_uop(bus.req_uop)) state_d = legal ? ST_ACCESS : ST_FAULT;
            ST_ACCESS: state_d = (bus.dc_uop == LDR_UOP) ? ST_WAIT : ST_IDLE;
            ST_WAIT:   if (cnt == '0) state_d = ST_RESP;
            ST_RESP:   if (bus.wb_ready) state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt;
        rd_d         = rd_q;
        dc_uop_d     = bus.dc_uop;
        dc_addr_d    = bus.dc_addr;
        dc_data_in_d = bus.dc_data_in;
        wb_valid_d   = bus.wb_valid;
        wb_rd_d      = bus.wb_rd;
        wb_data_d    = bus.wb_data;
        exc_valid_d  = 1'b0;
        exc_addr_d   = bus.exc_addr;
        req_ready_d  = (state_d == ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (accept && is_mem_uop(bus.req_uop)) begin
                    if (legal) begin
                        dc_uop_d     = bus.req_uop;
                        dc_addr_d    = word_addr;
                        dc_data_in_d = bus.req_data;
                        rd_d         = bus.req_rd;
                    end else begin
                        exc_valid_d  = 1'b1;
                        exc_addr_d   = ea;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = CNT_W'(READ_LATENCY - 1);
                if (bus.dc_uop != LDR_UOP) dc_uop_d = NOP_UOP;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    dc_uop_d   = NOP_UOP;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = bus.dc_data_out;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_RESP: if (bus.wb_ready) wb_valid_d = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench: lsu_ctrl (READ_LATENCY 1 and 3) against a small word-array dcache model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clock;
    logic reset;
    logic init_mem;
    int   checks;
    int   errors;

    logic [31:0] mem1 [32];
    logic [31:0] mem3 [32];

    lsu_ctrl_if ifc ();
    lsu_ctrl_if ifc3 ();

    lsu_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    lsu_ctrl #(.READ_LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // dcache model: write at the edge ending a STR cycle, drive read data only while LDR is presented
    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] <= 32'hC0DE0000 | i;
                mem3[i] <= 32'hC0DE0000 | i;
            end
        end else begin
            if (ifc.dc_uop == STR_UOP) mem1[ifc.dc_addr] <= ifc.dc_data_in;
            if (ifc3.dc_uop == STR_UOP) mem3[ifc3.dc_addr] <= ifc3.dc_data_in;
        end
    end

    assign ifc.dc_data_out  = (ifc.dc_uop == LDR_UOP) ? mem1[ifc.dc_addr] : 32'h0;
    assign ifc3.dc_data_out = (ifc3.dc_uop == LDR_UOP) ? mem3[ifc3.dc_addr] : 32'h0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [3:0] uop, input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] data, input logic [3:0] rd);
        int n;
        n = 0;
        while (ifc.req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL send_ready_timeout: got req_ready=%b want 1", ifc.req_ready);
        end
        ifc.req_valid  = 1'b1;
        ifc.req_uop    = uop;
        ifc.req_base   = base;
        ifc.req_offset = off;
        ifc.req_data   = data;
        ifc.req_rd     = rd;
        @(negedge clock);
        ifc.req_valid  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        init_mem = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL rst_dc_uop: got %h want %h", ifc.dc_uop, NOP_UOP); end
        checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", ifc.wb_valid); end
        checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", ifc.req_ready); end
        checks++; if (ifc.exc_valid !== 1'b0) begin errors++; $display("FAIL rst_exc_valid: got %b want 0", ifc.exc_valid); end
        checks++; if (ifc.dc_addr !== 5'd0) begin errors++; $display("FAIL rst_dc_addr: got %h want 0", ifc.dc_addr); end
        checks++; if (ifc.wb_data !== 32'd0) begin errors++; $display("FAIL rst_wb_data: got %h want 0", ifc.wb_data); end
        checks++; if (ifc3.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready3: got %b want 0", ifc3.req_ready); end
        reset = 1'b0;
        init_mem = 1'b0;
        @(negedge clock);
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready: got %b want 1", ifc.req_ready); end
    endtask

    task automatic test_store_load;
        send(STR_UOP, 32'h20, 32'h08, 32'h12345678, 4'd0);
        checks++; if (ifc.dc_uop !== STR_UOP) begin errors++; $display("FAIL st_dc_uop: got %h want %h", ifc.dc_uop, STR_UOP); end
        checks++; if (ifc.dc_addr !== 5'b01010) begin errors++; $display("FAIL st_dc_addr: got %b want 01010", ifc.dc_addr); end
        checks++; if (ifc.dc_data_in !== 32'h12345678) begin errors++; $display("FAIL st_dc_data_in: got %h want 12345678", ifc.dc_data_in); end
        checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL st_busy: got req_ready=%b want 0", ifc.req_ready); end
        @(negedge clock);
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL st_done_ready: got %b want 1", ifc.req_ready); end
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL st_done_uop: got %h want 0", ifc.dc_uop); end
        send(LDR_UOP, 32'h20, 32'h08, 32'h0, 4'd3);
        checks++; if (ifc.dc_uop !== LDR_UOP) begin errors++; $display("FAIL ld_dc_uop: got %h want %h", ifc.dc_uop, LDR_UOP); end
        checks++; if (ifc.dc_addr !== 5'b01010) begin errors++; $display("FAIL ld_dc_addr: got %b want 01010", ifc.dc_addr); end
        @(negedge clock);
        checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wb_early: got %b want 0", ifc.wb_valid); end
        checks++; if (ifc.dc_uop !== LDR_UOP) begin errors++; $display("FAIL ld_wait_uop: got %h want %h", ifc.dc_uop, LDR_UOP); end
        @(negedge clock);
        checks++; if (ifc.wb_valid !== 1'b1) begin errors++; $display("FAIL ld_wb_valid: got %b want 1", ifc.wb_valid); end
        checks++; if (ifc.wb_rd !== 4'd3) begin errors++; $display("FAIL ld_wb_rd: got %0d want 3", ifc.wb_rd); end
        checks++; if (ifc.wb_data !== 32'h12345678) begin errors++; $display("FAIL ld_wb_data: got %h want 12345678", ifc.wb_data); end
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL ld_resp_uop: got %h want 0", ifc.dc_uop); end
        @(negedge clock);
        checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wb_drop: got %b want 0", ifc.wb_valid); end
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL ld_idle_ready: got %b want 1", ifc.req_ready); end
    endtask

    task automatic test_wb_stall;
        send(STR_UOP, 32'h10, 32'h04, 32'hAABBCCDD, 4'd0);
        @(negedge clock);
        ifc.wb_ready = 1'b0;
        send(LDR_UOP, 32'h14, 32'h0, 32'h0, 4'd7);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            checks++; if (ifc.wb_valid !== 1'b1) begin errors++; $display("FAIL stall_wb_valid[%0d]: got %b want 1", k, ifc.wb_valid); end
            checks++; if (ifc.wb_data !== 32'hAABBCCDD) begin errors++; $display("FAIL stall_wb_data[%0d]: got %h want aabbccdd", k, ifc.wb_data); end
            checks++; if (ifc.wb_rd !== 4'd7) begin errors++; $display("FAIL stall_wb_rd[%0d]: got %0d want 7", k, ifc.wb_rd); end
            checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b want 0", k, ifc.req_ready); end
            @(negedge clock);
        end
        ifc.wb_ready = 1'b1;
        @(negedge clock);
        checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", ifc.wb_valid); end
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", ifc.req_ready); end
    endtask

    task automatic test_fault;
        send(LDR_UOP, 32'h20, 32'h02, 32'h0, 4'd1);
        checks++; if (ifc.exc_valid !== 1'b1) begin errors++; $display("FAIL mis_exc_valid: got %b want 1", ifc.exc_valid); end
        checks++; if (ifc.exc_addr !== 32'h22) begin errors++; $display("FAIL mis_exc_addr: got %h want 22", ifc.exc_addr); end
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL mis_dc_uop: got %h want 0", ifc.dc_uop); end
        @(negedge clock);
        checks++; if (ifc.exc_valid !== 1'b0) begin errors++; $display("FAIL mis_exc_pulse: got %b want 0", ifc.exc_valid); end
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL mis_dc_uop2: got %h want 0", ifc.dc_uop); end
        checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL mis_wb_valid: got %b want 0", ifc.wb_valid); end
        send(LDR_UOP, 32'h80, 32'h0, 32'h0, 4'd1);
        checks++; if (ifc.exc_valid !== 1'b1) begin errors++; $display("FAIL rng_exc_valid: got %b want 1", ifc.exc_valid); end
        checks++; if (ifc.exc_addr !== 32'h80) begin errors++; $display("FAIL rng_exc_addr: got %h want 80", ifc.exc_addr); end
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL rng_dc_uop: got %h want 0", ifc.dc_uop); end
        @(negedge clock);
        send(LDR_UOP, 32'hFFFFFFFC, 32'h4, 32'h0, 4'd2);
        checks++; if (ifc.exc_valid !== 1'b0) begin errors++; $display("FAIL wrap_exc_valid: got %b want 0", ifc.exc_valid); end
        checks++; if (ifc.dc_uop !== LDR_UOP) begin errors++; $display("FAIL wrap_dc_uop: got %h want %h", ifc.dc_uop, LDR_UOP); end
        checks++; if (ifc.dc_addr !== 5'd0) begin errors++; $display("FAIL wrap_dc_addr: got %h want 0", ifc.dc_addr); end
        repeat (2) @(negedge clock);
        checks++; if (ifc.wb_data !== 32'hC0DE0000) begin errors++; $display("FAIL wrap_wb_data: got %h want c0de0000", ifc.wb_data); end
        checks++; if (ifc.wb_rd !== 4'd2) begin errors++; $display("FAIL wrap_wb_rd: got %0d want 2", ifc.wb_rd); end
        @(negedge clock);
    endtask

    task automatic test_other_uop;
        send(4'b0010, 32'h8, 32'h0, 32'hDEADBEEF, 4'd5);
        for (int k = 0; k < 3; k++) begin
            checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL oth_dc_uop[%0d]: got %h want 0", k, ifc.dc_uop); end
            checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL oth_wb_valid[%0d]: got %b want 0", k, ifc.wb_valid); end
            checks++; if (ifc.exc_valid !== 1'b0) begin errors++; $display("FAIL oth_exc_valid[%0d]: got %b want 0", k, ifc.exc_valid); end
            checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL oth_req_ready[%0d]: got %b want 1", k, ifc.req_ready); end
            @(negedge clock);
        end
        checks++; if (mem1[2] !== 32'hC0DE0002) begin errors++; $display("FAIL oth_no_write: got %h want c0de0002", mem1[2]); end
    endtask

    task automatic test_reset_mid;
        send(LDR_UOP, 32'h28, 32'h0, 32'h0, 4'd4);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_wb_valid: got %b want 0", ifc.wb_valid); end
        checks++; if (ifc.dc_uop !== NOP_UOP) begin errors++; $display("FAIL rmid_dc_uop: got %h want 0", ifc.dc_uop); end
        checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL rmid_req_ready: got %b want 0", ifc.req_ready); end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_lost[%0d]: got wb_valid=%b want 0", k, ifc.wb_valid); end
        end
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle: got req_ready=%b want 1", ifc.req_ready); end
        send(STR_UOP, 32'h30, 32'h0, 32'h5555AAAA, 4'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (mem1[12] !== 32'h5555AAAA) begin errors++; $display("FAIL rst_store_mem: got %h want 5555aaaa", mem1[12]); end
        send(LDR_UOP, 32'h30, 32'h0, 32'h0, 4'd6);
        repeat (2) @(negedge clock);
        checks++; if (ifc.wb_data !== 32'h5555AAAA) begin errors++; $display("FAIL rst_store_load: got %h want 5555aaaa", ifc.wb_data); end
        @(negedge clock);
    endtask

    task automatic test_latency3;
        int n;
        n = 0;
        while (ifc3.req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL lat3_ready_timeout: got req_ready=%b want 1", ifc3.req_ready);
        end
        ifc3.req_valid  = 1'b1;
        ifc3.req_uop    = LDR_UOP;
        ifc3.req_base   = 32'h8;
        ifc3.req_offset = 32'h0;
        ifc3.req_rd     = 4'd9;
        @(negedge clock);
        ifc3.req_valid  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            checks++; if (ifc3.wb_valid !== 1'(k == 4)) begin errors++; $display("FAIL lat3_wb_valid[%0d]: got %b want %b", k, ifc3.wb_valid, 1'(k == 4)); end
        end
        checks++; if (ifc3.wb_data !== 32'hC0DE0002) begin errors++; $display("FAIL lat3_wb_data: got %h want c0de0002", ifc3.wb_data); end
        checks++; if (ifc3.wb_rd !== 4'd9) begin errors++; $display("FAIL lat3_wb_rd: got %0d want 9", ifc3.wb_rd); end
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        init_mem = 1'b1;
        ifc.req_valid = 1'b0;  ifc.req_uop = NOP_UOP;  ifc.req_base = '0;  ifc.req_offset = '0;
        ifc.req_data = '0;     ifc.req_rd = '0;        ifc.wb_ready = 1'b1;
        ifc3.req_valid = 1'b0; ifc3.req_uop = NOP_UOP; ifc3.req_base = '0; ifc3.req_offset = '0;
        ifc3.req_data = '0;    ifc3.req_rd = '0;       ifc3.wb_ready = 1'b1;

        test_reset();
        test_store_load();
        test_wb_stall();
        test_fault();
        test_other_uop();
        test_reset_mid();
        test_latency3();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
